// File: rtl/clb_cfg_loader.sv
// ---------------------------------------------------------------------------
// clb_cfg_loader
// Serial configuration loader feeding the CLB array. It hunts for a sync
// preamble, reads a 16-bit frame count, then deserialises one even-parity
// protected frame per CLB and strobes it into that CLB's config registers.
//
// Ports
//   K          clock, rising edge
//   RST_N      asynchronous active-low reset
//   DIN        serial config bit, MSB first
//   DIN_VALID  DIN is consumed on a K edge when 1; 0 stalls the loader
//   RESTART    synchronous return to preamble hunt; clears DONE/ERR
//   CFG_DATA   frame payload, held from one write strobe to the next
//   CFG_ADDR   target CLB index of the current strobe
//   CFG_WE     one-cycle write strobe to CLB[CFG_ADDR]
//   BUSY       high while reading the length, a frame, or its parity bit
//   DONE       all frames loaded (sticky until RESTART/reset)
//   ERR        load aborted (sticky until RESTART/reset)
//   ERR_CODE   01 = bad length, 10 = parity fail, 00 = none
// ---------------------------------------------------------------------------
module clb_cfg_loader #(
    parameter int          FRAME_W  = 37,
    parameter int          NUM_CLB  = 4,
    parameter int          ADDR_W   = 2,
    parameter logic [7:0]  PREAMBLE = 8'hF2
) (
    input  logic               K,
    input  logic               RST_N,
    input  logic               DIN,
    input  logic               DIN_VALID,
    input  logic               RESTART,
    output logic [FRAME_W-1:0] CFG_DATA,
    output logic [ADDR_W-1:0]  CFG_ADDR,
    output logic               CFG_WE,
    output logic               BUSY,
    output logic               DONE,
    output logic               ERR,
    output logic [1:0]         ERR_CODE
);

    typedef enum logic [2:0] {
        S_HUNT, S_LEN, S_DATA, S_PAR, S_DONE, S_ERROR
    } state_t;

    state_t              state_q, state_d;
    logic [7:0]          sr_q, sr_d;
    logic [15:0]         len_q, len_d;
    logic [5:0]          bitcnt_q, bitcnt_d;
    logic [FRAME_W-1:0]  payload_q, payload_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [FRAME_W-1:0]  cfg_data_q, cfg_data_d;
    logic [ADDR_W-1:0]   cfg_addr_q, cfg_addr_d;
    logic                cfg_we_q, cfg_we_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [1:0]          err_code_q, err_code_d;

    // Decodes shared by next-state and datapath logic.
    logic [15:0] len_shift;
    logic        len_ok, len_last, data_last, par_ok, frame_last, hunt_hit;

    assign len_shift  = {len_q[14:0], DIN};
    assign len_ok     = (len_shift != 16'd0) && (len_shift <= 16'(NUM_CLB));
    assign len_last   = (bitcnt_q == 6'd15);
    assign data_last  = (bitcnt_q == 6'(FRAME_W - 1));
    // Even parity: payload XOR parity bit must come out 0.
    assign par_ok     = ~(^payload_q ^ DIN);
    assign frame_last = ({{(16-ADDR_W){1'b0}}, idx_q} == (len_q - 16'd1));
    assign hunt_hit   = ({sr_q[6:0], DIN} == PREAMBLE);

    // State register and all datapath flops.
    always_ff @(posedge K or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= S_HUNT;
            sr_q       <= '0;
            len_q      <= '0;
            bitcnt_q   <= '0;
            payload_q  <= '0;
            idx_q      <= '0;
            cfg_data_q <= '0;
            cfg_addr_q <= '0;
            cfg_we_q   <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= 2'b00;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            len_q      <= len_d;
            bitcnt_q   <= bitcnt_d;
            payload_q  <= payload_d;
            idx_q      <= idx_d;
            cfg_data_q <= cfg_data_d;
            cfg_addr_q <= cfg_addr_d;
            cfg_we_q   <= cfg_we_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    // Next-state logic. RESTART beats a simultaneous valid bit.
    always_comb begin
        state_d = state_q;
        if (RESTART) begin
            state_d = S_HUNT;
        end else if (DIN_VALID) begin
            case (state_q)
                S_HUNT:  if (hunt_hit) state_d = S_LEN;
                S_LEN:   if (len_last) state_d = len_ok ? S_DATA : S_ERROR;
                S_DATA:  if (data_last) state_d = S_PAR;
                S_PAR: begin
                    if (!par_ok)        state_d = S_ERROR;
                    else if (frame_last) state_d = S_DONE;
                    else                state_d = S_DATA;
                end
                default: state_d = state_q;
            endcase
        end
    end

    // Datapath / registered-output next values.
    always_comb begin
        sr_d       = sr_q;
        len_d      = len_q;
        bitcnt_d   = bitcnt_q;
        payload_d  = payload_q;
        idx_d      = idx_q;
        cfg_data_d = cfg_data_q;
        cfg_addr_d = cfg_addr_q;
        cfg_we_d   = 1'b0;
        done_d     = done_q;
        err_d      = err_q;
        err_code_d = err_code_q;
        if (RESTART) begin
            // CFG_DATA/CFG_ADDR deliberately survive a restart.
            sr_d       = '0;
            len_d      = '0;
            bitcnt_d   = '0;
            payload_d  = '0;
            idx_d      = '0;
            done_d     = 1'b0;
            err_d      = 1'b0;
            err_code_d = 2'b00;
        end else if (DIN_VALID) begin
            case (state_q)
                S_HUNT: begin
                    sr_d     = {sr_q[6:0], DIN};
                    bitcnt_d = '0;
                    len_d    = '0;
                end
                S_LEN: begin
                    len_d = len_shift;
                    if (len_last) begin
                        bitcnt_d = '0;
                        idx_d    = '0;
                        if (!len_ok) begin
                            err_d      = 1'b1;
                            err_code_d = 2'b01;
                        end
                    end else begin
                        bitcnt_d = bitcnt_q + 6'd1;
                    end
                end
                S_DATA: begin
                    payload_d = {payload_q[FRAME_W-2:0], DIN};
                    bitcnt_d  = data_last ? 6'd0 : bitcnt_q + 6'd1;
                end
                S_PAR: begin
                    if (par_ok) begin
                        cfg_we_d   = 1'b1;
                        cfg_data_d = payload_q;
                        cfg_addr_d = idx_q;
                        if (frame_last) done_d = 1'b1;
                        else            idx_d  = idx_q + 1'b1;
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = 2'b10;
                    end
                end
                default: ;
            endcase
        end
    end

    // Output decode.
    always_comb begin
        BUSY = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_PAR);
    end

    assign CFG_DATA = cfg_data_q;
    assign CFG_ADDR = cfg_addr_q;
    assign CFG_WE   = cfg_we_q;
    assign DONE     = done_q;
    assign ERR      = err_q;
    assign ERR_CODE = err_code_q;

endmodule

// File: tb/tb_clb_cfg_loader.sv
// ---------------------------------------------------------------------------
// tb_clb_cfg_loader
// Directed bench for clb_cfg_loader: happy path, full chain with stalls,
// bad length, parity fail, preamble hunt, RESTART and async reset mid-frame.
// ---------------------------------------------------------------------------
module tb_clb_cfg_loader;

    logic        K = 1'b0;
    logic        RST_N = 1'b0;
    logic        DIN = 1'b0;
    logic        DIN_VALID = 1'b0;
    logic        RESTART = 1'b0;
    logic [36:0] CFG_DATA;
    logic [1:0]  CFG_ADDR;
    logic        CFG_WE;
    logic        BUSY;
    logic        DONE;
    logic        ERR;
    logic [1:0]  ERR_CODE;

    int tests = 0;
    int fails = 0;
    int both_cnt = 0;

    logic [1:0]  we_addr[$];
    logic [36:0] we_data[$];
    logic        we_done[$];

    clb_cfg_loader dut (
        .K(K), .RST_N(RST_N), .DIN(DIN), .DIN_VALID(DIN_VALID), .RESTART(RESTART),
        .CFG_DATA(CFG_DATA), .CFG_ADDR(CFG_ADDR), .CFG_WE(CFG_WE), .BUSY(BUSY),
        .DONE(DONE), .ERR(ERR), .ERR_CODE(ERR_CODE)
    );

    always #5 K = ~K;

    // Strobe logger and DONE/ERR exclusivity watcher, sampled mid-cycle.
    always @(negedge K) begin
        if (CFG_WE) begin
            we_addr.push_back(CFG_ADDR);
            we_data.push_back(CFG_DATA);
            we_done.push_back(DONE);
        end
        if (DONE && ERR) both_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic b);
        @(negedge K);
        DIN_VALID = v;
        DIN = b;
    endtask

    task automatic send_bits(input logic [63:0] val, input int n, input bit stall);
        for (int i = n - 1; i >= 0; i--) begin
            step(1'b1, val[i]);
            if (stall) step(1'b0, 1'b0);
        end
    endtask

    task automatic send_hdr(input logic [15:0] len, input bit stall);
        send_bits(64'hF2, 8, stall);
        send_bits(64'(len), 16, stall);
    endtask

    task automatic send_frame(input logic [36:0] d, input logic flip, input bit stall);
        send_bits(64'(d), 37, stall);
        send_bits(64'((^d) ^ flip), 1, stall);
    endtask

    task automatic do_restart();
        @(negedge K);
        RESTART = 1'b1;
        DIN_VALID = 1'b1;
        DIN = 1'b1;
        @(negedge K);
        RESTART = 1'b0;
        DIN_VALID = 1'b0;
        DIN = 1'b0;
    endtask

    task automatic clear_log();
        we_addr.delete();
        we_data.delete();
        we_done.delete();
    endtask

    initial begin
        logic [36:0] fr[4];
        logic [13:0] hunt_bits;
        logic        early;

        // Reset state
        #3;
        chk("reset_outputs", 64'({CFG_DATA, CFG_ADDR, CFG_WE, BUSY, DONE, ERR, ERR_CODE}), 64'd0);
        @(negedge K);
        @(negedge K);
        RST_N = 1'b1;
        step(1'b0, 1'b0);
        chk("idle_busy", 64'(BUSY), 64'd0);

        // 1. Happy path
        send_bits(64'b111, 3, 1'b0);
        send_bits(64'hF2, 8, 1'b0);
        step(1'b0, 1'b0);
        chk("t1_lock_busy", 64'(BUSY), 64'd1);
        send_bits(64'h0001, 16, 1'b0);
        send_bits(64'h0_22C5_4038, 37, 1'b0);
        send_bits(64'd0, 1, 1'b0);
        step(1'b0, 1'b0);
        chk("t1_we", 64'(CFG_WE), 64'd1);
        chk("t1_addr", 64'(CFG_ADDR), 64'd0);
        chk("t1_data", 64'(CFG_DATA), 64'h0_22C5_4038);
        chk("t1_done", 64'(DONE), 64'd1);
        step(1'b0, 1'b0);
        chk("t1_we_pulse", 64'({CFG_WE, BUSY, ERR}), 64'd0);
        chk("t1_we_count", 64'(we_addr.size()), 64'd1);

        // 2. Full chain with DIN_VALID toggling
        fr[0] = 37'h1_0000_0001;
        fr[1] = 37'h0_ABCD_1234;
        fr[2] = 37'h1_FFFF_FFFF;
        fr[3] = 37'h0_22C5_4038;
        do_restart();
        chk("restart_clear", 64'({DONE, ERR, CFG_WE, BUSY}), 64'd0);
        chk("restart_keep", 64'(CFG_DATA), 64'h0_22C5_4038);
        clear_log();
        send_hdr(16'd4, 1'b1);
        for (int i = 0; i < 4; i++) send_frame(fr[i], 1'b0, 1'b1);
        chk("t2_we_latency", 64'({CFG_WE, DONE}), 64'b11);
        step(1'b0, 1'b0);
        chk("t2_we_count", 64'(we_addr.size()), 64'd4);
        if (we_addr.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("t2_addr%0d", i), 64'(we_addr[i]), 64'(i));
                chk($sformatf("t2_data%0d", i), 64'(we_data[i]), 64'(fr[i]));
                chk($sformatf("t2_done%0d", i), 64'(we_done[i]), 64'(i == 3));
            end
        end
        chk("t2_busy_after", 64'({BUSY, DONE, ERR}), 64'b010);

        // 3. Bad length: 0, then 5
        do_restart();
        clear_log();
        send_hdr(16'd0, 1'b0);
        step(1'b0, 1'b0);
        chk("t3_len0", 64'({ERR, ERR_CODE, BUSY, DONE}), 64'b10100);
        send_bits(64'hFFFF_FFFF, 32, 1'b0);
        step(1'b0, 1'b0);
        chk("t3_err_sticky", 64'({ERR, ERR_CODE, BUSY}), 64'b1010);
        do_restart();
        chk("t3_restart", 64'({ERR, ERR_CODE}), 64'd0);
        send_hdr(16'd5, 1'b0);
        step(1'b0, 1'b0);
        chk("t3_len5", 64'({ERR, ERR_CODE, BUSY, DONE}), 64'b10100);
        chk("t3_no_we", 64'(we_addr.size()), 64'd0);

        // 4. Parity fail on frame 1
        do_restart();
        clear_log();
        send_hdr(16'd2, 1'b0);
        send_frame(37'h0_5555_AAAA, 1'b0, 1'b0);
        send_frame(37'h1_0F0F_0F0F, 1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk("t4_we_count", 64'(we_addr.size()), 64'd1);
        if (we_addr.size() >= 1) chk("t4_addr", 64'(we_addr[0]), 64'd0);
        chk("t4_data_kept", 64'(CFG_DATA), 64'h0_5555_AAAA);
        chk("t4_err", 64'({ERR, ERR_CODE, DONE, BUSY}), 64'b11000);

        // 5. Preamble hunt with near-miss patterns
        do_restart();
        clear_log();
        hunt_bits = 14'b11110011110010;
        early = 1'b0;
        for (int i = 13; i >= 1; i--) begin
            send_bits(64'(hunt_bits[i]), 1, 1'b0);
            step(1'b0, 1'b0);
            if (BUSY) early = 1'b1;
        end
        chk("t5_no_early_lock", 64'(early), 64'd0);
        send_bits(64'(hunt_bits[0]), 1, 1'b0);
        step(1'b0, 1'b0);
        chk("t5_lock", 64'(BUSY), 64'd1);
        send_bits(64'h0001, 16, 1'b0);
        send_frame(37'h0_0000_0007, 1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk("t5_done", 64'({DONE, we_addr.size() == 1}), 64'b11);

        // 6. RESTART mid-frame, then a clean single-frame load
        do_restart();
        clear_log();
        send_hdr(16'd2, 1'b0);
        send_frame(37'h0_1234_5678, 1'b0, 1'b0);
        send_bits(64'h3FF, 10, 1'b0);
        do_restart();
        chk("t6_restart_busy", 64'({BUSY, DONE, ERR}), 64'd0);
        chk("t6_partial_no_we", 64'(we_addr.size()), 64'd1);
        send_hdr(16'd1, 1'b0);
        send_frame(37'h1_8000_0003, 1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk("t6_we_count", 64'(we_addr.size()), 64'd2);
        if (we_addr.size() == 2) begin
            chk("t6_addr", 64'(we_addr[1]), 64'd0);
            chk("t6_data", 64'(we_data[1]), 64'h1_8000_0003);
        end
        chk("t6_done", 64'(DONE), 64'd1);

        // Async reset mid-DATA
        do_restart();
        send_hdr(16'd1, 1'b0);
        send_bits(64'hFFFFF, 20, 1'b0);
        @(negedge K);
        DIN_VALID = 1'b0;
        #2;
        RST_N = 1'b0;
        #1;
        chk("t6_async_reset", 64'({CFG_DATA, CFG_ADDR, CFG_WE, BUSY, DONE, ERR, ERR_CODE}), 64'd0);
        @(negedge K);
        RST_N = 1'b1;
        step(1'b0, 1'b0);
        chk("t6_after_reset", 64'({BUSY, CFG_WE}), 64'd0);

        chk("done_err_exclusive", 64'(both_cnt), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
